// File: rtl/demux_stream_1ton_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;

    // Packet-level routing state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for the first beat of a packet
        PASS = 2'd1,   // channel lock is held until the last beat
        DROP = 2'd2    // discarding the remainder of an illegal packet
    } state_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_stream_1ton_stream_reg.sv
// One-entry valid/ready pipeline register. Accepts a new word in the same
// cycle the held word drains, so a full register sustains one word per cycle.
module stream_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // Upstream may write whenever the slot is empty or is draining this cycle.
    assign s_ready = !valid_q || m_ready;
    assign m_valid = valid_q;
    assign m_data  = data_q;

    // Next contents: load wins over drain; data is kept after a drain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (s_valid && s_ready) begin
            valid_d = 1'b1;
            data_d  = s_data;
        end else if (m_ready) begin
            valid_d = 1'b0;
        end
    end

    // Storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N packet demultiplexer. The first beat of a packet picks the
// channel; the channel stays locked until the last beat. Packets whose select
// is out of range are swallowed and counted.
module demux_stream_1ton
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = clog2(N),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_last,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int              PAY_W = WIDTH + 1 + SEL_W;
    localparam logic [SEL_W:0]  N_L   = N[SEL_W:0];

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   lock_q, lock_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               sel_legal;
    logic               accept;
    logic [SEL_W-1:0]   dest_ch;
    logic               reg_s_valid, reg_s_ready;
    logic               reg_m_valid, reg_m_ready;
    logic [PAY_W-1:0]   reg_s_data, reg_m_data;
    logic [SEL_W-1:0]   reg_ch;

    // Select legality is only meaningful on a first beat (IDLE).
    assign sel_legal   = ({1'b0, in_sel} < N_L);
    assign accept      = in_valid && in_ready;
    assign dest_ch     = (state_q == IDLE) ? in_sel : lock_q;
    assign reg_s_valid = in_valid && (((state_q == IDLE) && sel_legal) || (state_q == PASS));
    assign reg_s_data  = {in_data, in_last, dest_ch};

    stream_reg #(
        .DW (PAY_W)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .s_valid (reg_s_valid),
        .s_ready (reg_s_ready),
        .s_data  (reg_s_data),
        .m_valid (reg_m_valid),
        .m_ready (reg_m_ready),
        .m_data  (reg_m_data)
    );

    assign out_data = reg_m_data[PAY_W-1 -: WIDTH];
    assign out_last = reg_m_data[SEL_W];
    assign reg_ch   = reg_m_data[SEL_W-1:0];

    // One-hot valid decode of the held beat's channel.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_decode
            assign out_valid[gi] = reg_m_valid && (reg_ch == SEL_W'(gi));
        end
    endgenerate

    // Only the addressed channel's ready can drain the register.
    assign reg_m_ready = |(out_valid & out_ready);

    // State, lock and drop counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Next-state: packet framing, channel lock and drop accounting.
    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (sel_legal) begin
                        lock_d  = in_sel;
                        state_d = in_last ? IDLE : PASS;
                    end else begin
                        if (!(&drop_cnt_q)) begin
                            drop_cnt_d = drop_cnt_q + 1'b1;
                        end
                        state_d = in_last ? IDLE : DROP;
                    end
                end
                PASS:    if (in_last) state_d = IDLE;
                DROP:    if (in_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs: a dropping packet is always accepted; otherwise follow the register.
    always_comb begin
        in_ready = reg_s_ready;
        if (state_q == DROP) begin
            in_ready = 1'b1;
        end
        busy     = (state_q != IDLE) || reg_m_valid;
        drop_cnt = drop_cnt_q;
    end

endmodule
